// File: rtl/mdu_sequencer.sv
// Iterative shift-add multiply / multiply-accumulate engine.
// Owns the architectural HI/LO accumulator pair beside the ALU.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MADDU = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       op_q, op_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [W2-1:0]    prod_q, prod_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             accept;
  logic             sgn_op;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    prod_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
    end
  end

  // Min-int negates to itself; read unsigned that is the 2^(W-1) magnitude.
  always_comb begin
    sgn_op = (op != OP_MADDU);
    mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
    prod_s = neg_q ? -prod_q : prod_q;
    accept = start &&
             ((state_q == S_IDLE) || (state_q == S_DONE));
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          op_d = op;
          if (op == OP_CLR) begin
            state_d = S_DONE;
            hi_d    = '0;
            lo_d    = '0;
          end else begin
            state_d  = S_MUL;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            prod_d   = '0;
            neg_d    = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_d    = CW'(WIDTH);
          end
        end
      end
      S_MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_d == '0) begin
          state_d = S_ACC;
        end
      end
      S_ACC: begin
        state_d = S_DONE;
        if (op_q == OP_MUL) begin
          res_d = prod_s[WIDTH-1:0];
        end else begin
          {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q == S_MUL) || (state_q == S_ACC);
  assign done   = (state_q == S_DONE);
  assign result = res_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule
